// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU result and control, holds NZCV, drives
// the EX/MEM forwarding path and counts instructions retired into MEM.
module ex_mem_stage #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned REGADDR = 5,
  parameter int unsigned CNTW    = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ex_valid,
  input  logic [WIDTH-1:0]   ex_result,
  input  logic               ex_carry,
  input  logic               ex_overflow,
  input  logic               ex_set_flags,
  input  logic [REGADDR-1:0] ex_rd,
  input  logic               ex_reg_write,
  input  logic               ex_mem_read,
  input  logic               ex_mem_write,
  input  logic [WIDTH-1:0]   ex_store_data,
  input  logic               stall,
  input  logic               flush,
  output logic               ex_zero,
  output logic               mem_valid,
  output logic [WIDTH-1:0]   mem_result,
  output logic [REGADDR-1:0] mem_rd,
  output logic               mem_reg_write,
  output logic               mem_mem_read,
  output logic               mem_mem_write,
  output logic [WIDTH-1:0]   mem_store_data,
  output logic               flag_n,
  output logic               flag_z,
  output logic               flag_c,
  output logic               flag_v,
  output logic               fwd_valid,
  output logic [REGADDR-1:0] fwd_rd,
  output logic [WIDTH-1:0]   fwd_data,
  output logic [CNTW-1:0]    instr_count
);

  localparam logic [REGADDR-1:0] XzrIdx = REGADDR'(31);

  logic               r_valid;
  logic [WIDTH-1:0]   r_result;
  logic [REGADDR-1:0] r_rd;
  logic               r_reg_write;
  logic               r_mem_read;
  logic               r_mem_write;
  logic [WIDTH-1:0]   r_store_data;
  logic               r_n, r_z, r_c, r_v;
  logic [CNTW-1:0]    r_count;

  logic w_zero;
  logic w_set_flags;

  assign w_zero      = (ex_result == '0);
  assign w_set_flags = ex_valid & ex_set_flags;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid      <= 1'b0;
      r_result     <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_store_data <= '0;
      r_n          <= 1'b0;
      r_z          <= 1'b0;
      r_c          <= 1'b0;
      r_v          <= 1'b0;
      r_count      <= '0;
    end else if (flush) begin
      // Bubble: flags and counter are left untouched.
      r_valid      <= 1'b0;
      r_result     <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_store_data <= '0;
    end else if (!stall) begin
      r_valid      <= ex_valid;
      r_result     <= ex_result;
      r_rd         <= ex_rd;
      r_reg_write  <= ex_valid & ex_reg_write & (ex_rd != XzrIdx);
      r_mem_read   <= ex_valid & ex_mem_read;
      r_mem_write  <= ex_valid & ex_mem_write;
      r_store_data <= ex_store_data;
      if (w_set_flags) begin
        r_n <= ex_result[WIDTH-1];
        r_z <= w_zero;
        r_c <= ex_carry;
        r_v <= ex_overflow;
      end
      if (ex_valid) begin
        r_count <= r_count + CNTW'(1);
      end
    end
  end

  assign ex_zero        = w_zero;
  assign mem_valid      = r_valid;
  assign mem_result     = r_result;
  assign mem_rd         = r_rd;
  assign mem_reg_write  = r_reg_write;
  assign mem_mem_read   = r_mem_read;
  assign mem_mem_write  = r_mem_write;
  assign mem_store_data = r_store_data;
  assign flag_n         = r_n;
  assign flag_z         = r_z;
  assign flag_c         = r_c;
  assign flag_v         = r_v;
  // Load data only exists after MEM, so loads are not a forwarding source here.
  assign fwd_valid      = r_valid & r_reg_write & ~r_mem_read;
  assign fwd_rd         = r_rd;
  assign fwd_data       = r_result;
  assign instr_count    = r_count;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: stimulus pushes hand-computed expected
// MEM-side state; a monitor pops and compares one entry after each rising edge.
module tb_ex_mem_stage;

  localparam int unsigned WIDTH   = 64;
  localparam int unsigned REGADDR = 5;
  localparam int unsigned CNTW    = 4;

  typedef struct packed {
    logic        valid;
    logic [63:0] result;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [63:0] sd;
    logic [3:0]  nzcv;
    logic [3:0]  cnt;
    logic        fwd;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               ex_valid = 1'b0;
  logic [WIDTH-1:0]   ex_result = '0;
  logic               ex_carry = 1'b0;
  logic               ex_overflow = 1'b0;
  logic               ex_set_flags = 1'b0;
  logic [REGADDR-1:0] ex_rd = '0;
  logic               ex_reg_write = 1'b0;
  logic               ex_mem_read = 1'b0;
  logic               ex_mem_write = 1'b0;
  logic [WIDTH-1:0]   ex_store_data = '0;
  logic               stall = 1'b0;
  logic               flush = 1'b0;
  logic               ex_zero;
  logic               mem_valid;
  logic [WIDTH-1:0]   mem_result;
  logic [REGADDR-1:0] mem_rd;
  logic               mem_reg_write;
  logic               mem_mem_read;
  logic               mem_mem_write;
  logic [WIDTH-1:0]   mem_store_data;
  logic               flag_n, flag_z, flag_c, flag_v;
  logic               fwd_valid;
  logic [REGADDR-1:0] fwd_rd;
  logic [WIDTH-1:0]   fwd_data;
  logic [CNTW-1:0]    instr_count;

  int tests = 0;
  int fails = 0;
  exp_t q[$];
  exp_t last;

  ex_mem_stage #(.WIDTH(WIDTH), .REGADDR(REGADDR), .CNTW(CNTW)) dut (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_carry(ex_carry), .ex_overflow(ex_overflow), .ex_set_flags(ex_set_flags),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data), .stall(stall),
    .flush(flush), .ex_zero(ex_zero), .mem_valid(mem_valid), .mem_result(mem_result),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_store_data(mem_store_data), .flag_n(flag_n),
    .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic exp_t mk(input logic v, input logic [63:0] res, input logic [4:0] rd,
                              input logic rw, input logic mr, input logic mw,
                              input logic [63:0] sd, input logic [3:0] nzcv,
                              input logic [3:0] cnt, input logic fwd);
    exp_t e;
    e.valid = v; e.result = res; e.rd = rd; e.rw = rw; e.mr = mr; e.mw = mw;
    e.sd = sd; e.nzcv = nzcv; e.cnt = cnt; e.fwd = fwd;
    return e;
  endfunction

  function automatic void chk_state(input string tag, input exp_t e);
    chk({tag, ".valid"}, 64'(mem_valid), 64'(e.valid));
    chk({tag, ".result"}, mem_result, e.result);
    chk({tag, ".rd"}, 64'(mem_rd), 64'(e.rd));
    chk({tag, ".reg_write"}, 64'(mem_reg_write), 64'(e.rw));
    chk({tag, ".mem_read"}, 64'(mem_mem_read), 64'(e.mr));
    chk({tag, ".mem_write"}, 64'(mem_mem_write), 64'(e.mw));
    chk({tag, ".store_data"}, mem_store_data, e.sd);
    chk({tag, ".nzcv"}, 64'({flag_n, flag_z, flag_c, flag_v}), 64'(e.nzcv));
    chk({tag, ".count"}, 64'(instr_count), 64'(e.cnt));
    chk({tag, ".fwd_valid"}, 64'(fwd_valid), 64'(e.fwd));
    chk({tag, ".fwd_rd"}, 64'(fwd_rd), 64'(e.rd));
    chk({tag, ".fwd_data"}, fwd_data, e.result);
  endfunction

  // Drive one cycle of EX inputs and queue the MEM-side state expected after the edge.
  task automatic cyc(input logic v, input logic [63:0] res, input logic c, input logic ov,
                     input logic sf, input logic [4:0] rd, input logic rw, input logic mr,
                     input logic mw, input logic [63:0] sd, input logic st, input logic fl,
                     input exp_t e);
    @(negedge clk);
    ex_valid = v; ex_result = res; ex_carry = c; ex_overflow = ov; ex_set_flags = sf;
    ex_rd = rd; ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw;
    ex_store_data = sd; stall = st; flush = fl;
    q.push_back(e);
    last = e;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk_state("sb", e);
      end
    end
  end

  initial begin : stim
    #3;
    chk_state("reset", mk(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
    @(negedge clk);
    reset_n = 1'b1;

    cyc(1, 64'h00F0, 0, 0, 0, 5'd3, 1, 0, 0, 0, 0, 0,
        mk(1, 64'h00F0, 5'd3, 1, 0, 0, 0, 4'b0000, 4'd1, 1));
    // SUBS yielding zero: Z and C set
    cyc(1, 64'h0, 1, 0, 1, 5'd4, 1, 0, 0, 0, 0, 0,
        mk(1, 64'h0, 5'd4, 1, 0, 0, 0, 4'b0110, 4'd2, 1));
    #1 chk("ex_zero_hi", 64'(ex_zero), 64'd1);
    cyc(1, 64'h8000_0000_0000_0000, 1, 1, 0, 5'd5, 1, 0, 0, 0, 0, 0,
        mk(1, 64'h8000_0000_0000_0000, 5'd5, 1, 0, 0, 0, 4'b0110, 4'd3, 1));
    #1 chk("ex_zero_lo", 64'(ex_zero), 64'd0);
    cyc(1, 64'h11, 0, 0, 0, 5'd31, 1, 0, 0, 0, 0, 0,
        mk(1, 64'h11, 5'd31, 0, 0, 0, 0, 4'b0110, 4'd4, 0));
    cyc(1, 64'h100, 0, 0, 0, 5'd7, 1, 1, 0, 0, 0, 0,
        mk(1, 64'h100, 5'd7, 1, 1, 0, 0, 4'b0110, 4'd5, 0));
    cyc(1, 64'h200, 0, 0, 0, 5'd0, 0, 0, 1, 64'hDEAD, 0, 0,
        mk(1, 64'h200, 5'd0, 0, 0, 1, 64'hDEAD, 4'b0110, 4'd6, 0));
    // ADDS negative with overflow
    cyc(1, 64'h8000_0000_0000_0001, 0, 1, 1, 5'd2, 1, 0, 0, 0, 0, 0,
        mk(1, 64'h8000_0000_0000_0001, 5'd2, 1, 0, 0, 0, 4'b1001, 4'd7, 1));
    for (int i = 0; i < 3; i++) begin
      cyc(1, 64'(i), 1, 0, 1, 5'(10 + i), 1, i[0], ~i[0], 64'h99, 1, 0, last);
    end
    // Invalid EX: data loads, control and flags do not
    cyc(0, 64'h55, 1, 1, 1, 5'd9, 1, 1, 1, 64'h77, 0, 0,
        mk(0, 64'h55, 5'd9, 0, 0, 0, 64'h77, 4'b1001, 4'd7, 0));
    cyc(1, 64'h33, 0, 0, 0, 5'd1, 1, 0, 0, 0, 0, 0,
        mk(1, 64'h33, 5'd1, 1, 0, 0, 0, 4'b1001, 4'd8, 1));
    cyc(1, 64'h0, 1, 1, 1, 5'd6, 1, 0, 0, 64'h44, 1, 1,
        mk(0, 64'h0, 5'd0, 0, 0, 0, 0, 4'b1001, 4'd8, 0));
    for (int i = 0; i < 8; i++) begin
      cyc(1, 64'(i + 1), 0, 0, 0, 5'd1, 1, 0, 0, 0, 0, 0,
          mk(1, 64'(i + 1), 5'd1, 1, 0, 0, 0, 4'b1001, 4'(9 + i), 1));
    end
    @(negedge clk);
    ex_valid = 1'b0; ex_reg_write = 1'b0; stall = 1'b1;
    @(posedge clk);
    #2;
    chk("queue_drained", 64'(q.size()), 64'd0);
    // Asynchronous reset mid-cycle, checked before any further clock edge
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_state("async_reset", mk(0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'd0, 0));
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1, 64'hABC, 0, 0, 0, 5'd8, 1, 0, 0, 0, 0, 0,
        mk(1, 64'hABC, 5'd8, 1, 0, 0, 0, 4'b0000, 4'd1, 1));
    @(negedge clk);
    stall = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("queue_final", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
